// File: rtl/mem_req_buffer.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_buffer
// Purpose  : Decouples a core's memory request and write-data channels from
//            external memory. Requests {rw, addr, tag} and write data
//            {bits, mask} are queued in two independent DEPTH-entry FIFOs and
//            re-issued downstream as request, then (for writes) its data beat.
// Ports    : clk, reset (synchronous, active-low)
//            up_req_*   : upstream request channel  (valid/ready, rw/addr/tag)
//            up_data_*  : upstream write-data channel (valid/ready, bits/mask)
//            dn_req_*   : downstream request channel
//            dn_data_*  : downstream write-data channel
//            dbg_req_cnt / dbg_stall_cnt : statistics counters
// Options  : MEM_REQ_BUF_STATS_EN - when defined, builds the statistics
//            counters; otherwise both dbg outputs are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int TAG_W  = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                up_req_valid,
  input  logic                up_req_rw,
  input  logic [ADDR_W-1:0]   up_req_addr,
  input  logic [TAG_W-1:0]    up_req_tag,
  output logic                up_req_ready,
  input  logic                up_data_valid,
  input  logic [DATA_W-1:0]   up_data_bits,
  input  logic [DATA_W/8-1:0] up_data_mask,
  output logic                up_data_ready,
  output logic                dn_req_valid,
  output logic                dn_req_rw,
  output logic [ADDR_W-1:0]   dn_req_addr,
  output logic [TAG_W-1:0]    dn_req_tag,
  input  logic                dn_req_ready,
  output logic                dn_data_valid,
  output logic [DATA_W-1:0]   dn_data_bits,
  output logic [DATA_W/8-1:0] dn_data_mask,
  input  logic                dn_data_ready,
  output logic [31:0]         dbg_req_cnt,
  output logic [31:0]         dbg_stall_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [0:0] D_REQ   = 1'b0;
  localparam logic [0:0] D_WDATA = 1'b1;

  // Request FIFO storage
  logic              r_req_rw   [DEPTH];
  logic [ADDR_W-1:0] r_req_addr [DEPTH];
  logic [TAG_W-1:0]  r_req_tag  [DEPTH];
  logic [PTR_W-1:0]  r_req_wr, r_req_rd;
  logic [CNT_W-1:0]  r_req_cnt;

  // Data FIFO storage
  logic [DATA_W-1:0]   r_dat_bits [DEPTH];
  logic [DATA_W/8-1:0] r_dat_mask [DEPTH];
  logic [PTR_W-1:0]    r_dat_wr, r_dat_rd;
  logic [CNT_W-1:0]    r_dat_cnt;

  logic [0:0] r_state;
  logic [0:0] w_state_nxt;

  logic w_req_push, w_req_pop, w_dat_push, w_dat_pop;
  logic w_req_nempty, w_dat_nempty, w_head_rw;
  logic w_dn_req_valid, w_dn_data_valid;

  assign w_req_nempty = (r_req_cnt != '0);
  assign w_dat_nempty = (r_dat_cnt != '0);
  assign w_head_rw    = r_req_rw[r_req_rd];

  // Readiness is purely "not full" (no bypass) and forced low while in reset.
  assign up_req_ready  = reset && (r_req_cnt != CNT_W'(DEPTH));
  assign up_data_ready = reset && (r_dat_cnt != CNT_W'(DEPTH));

  assign w_req_push = up_req_valid  && up_req_ready;
  assign w_dat_push = up_data_valid && up_data_ready;
  assign w_req_pop  = w_dn_req_valid  && dn_req_ready;
  assign w_dat_pop  = w_dn_data_valid && dn_data_ready;

  // ---------------- Request FIFO ----------------
  always_ff @(posedge clk) begin
    if (w_req_push) begin
      r_req_rw[r_req_wr]   <= up_req_rw;
      r_req_addr[r_req_wr] <= up_req_addr;
      r_req_tag[r_req_wr]  <= up_req_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_req_wr  <= '0;
      r_req_rd  <= '0;
      r_req_cnt <= '0;
    end else begin
      if (w_req_push) r_req_wr <= r_req_wr + 1'b1;
      if (w_req_pop)  r_req_rd <= r_req_rd + 1'b1;
      case ({w_req_push, w_req_pop})
        2'b10:   r_req_cnt <= r_req_cnt + 1'b1;
        2'b01:   r_req_cnt <= r_req_cnt - 1'b1;
        default: r_req_cnt <= r_req_cnt;
      endcase
    end
  end

  // ---------------- Data FIFO ----------------
  always_ff @(posedge clk) begin
    if (w_dat_push) begin
      r_dat_bits[r_dat_wr] <= up_data_bits;
      r_dat_mask[r_dat_wr] <= up_data_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_dat_wr  <= '0;
      r_dat_rd  <= '0;
      r_dat_cnt <= '0;
    end else begin
      if (w_dat_push) r_dat_wr <= r_dat_wr + 1'b1;
      if (w_dat_pop)  r_dat_rd <= r_dat_rd + 1'b1;
      case ({w_dat_push, w_dat_pop})
        2'b10:   r_dat_cnt <= r_dat_cnt + 1'b1;
        2'b01:   r_dat_cnt <= r_dat_cnt - 1'b1;
        default: r_dat_cnt <= r_dat_cnt;
      endcase
    end
  end

  // ---------------- Downstream FSM ----------------
  always_ff @(posedge clk) begin
    if (!reset) r_state <= D_REQ;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      D_REQ:   if (w_req_pop && w_head_rw) w_state_nxt = D_WDATA;
      D_WDATA: if (w_dat_pop)              w_state_nxt = D_REQ;
      default: w_state_nxt = D_REQ;
    endcase
  end

  // A write request is only offered once its data beat is already queued, so
  // D_WDATA always has a valid data head and never has to wait on upstream.
  always_comb begin
    w_dn_req_valid  = 1'b0;
    w_dn_data_valid = 1'b0;
    case (r_state)
      D_REQ:   w_dn_req_valid  = reset && w_req_nempty && (!w_head_rw || w_dat_nempty);
      D_WDATA: w_dn_data_valid = reset;
      default: begin
        w_dn_req_valid  = 1'b0;
        w_dn_data_valid = 1'b0;
      end
    endcase
  end

  assign dn_req_valid  = w_dn_req_valid;
  assign dn_req_rw     = w_head_rw;
  assign dn_req_addr   = r_req_addr[r_req_rd];
  assign dn_req_tag    = r_req_tag[r_req_rd];
  assign dn_data_valid = w_dn_data_valid;
  assign dn_data_bits  = r_dat_bits[r_dat_rd];
  assign dn_data_mask  = r_dat_mask[r_dat_rd];

  // ---------------- Statistics ----------------
`ifdef MEM_REQ_BUF_STATS_EN
  logic [31:0] r_req_stat;
  logic [31:0] r_stall_stat;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_req_stat   <= '0;
      r_stall_stat <= '0;
    end else begin
      if (w_req_pop)                     r_req_stat   <= r_req_stat + 1'b1;
      if (up_req_valid && !up_req_ready) r_stall_stat <= r_stall_stat + 1'b1;
    end
  end

  assign dbg_req_cnt   = r_req_stat;
  assign dbg_stall_cnt = r_stall_stat;
`else
  assign dbg_req_cnt   = '0;
  assign dbg_stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_req_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_req_buffer
// Purpose  : Directed self-checking bench for mem_req_buffer (DEPTH=4).
//            Statistics expectations follow MEM_REQ_BUF_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_req_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic         up_req_valid, up_req_rw;
  logic [27:0]  up_req_addr;
  logic [4:0]   up_req_tag;
  logic         up_req_ready;
  logic         up_data_valid;
  logic [127:0] up_data_bits;
  logic [15:0]  up_data_mask;
  logic         up_data_ready;
  logic         dn_req_valid, dn_req_rw, dn_req_ready;
  logic [27:0]  dn_req_addr;
  logic [4:0]   dn_req_tag;
  logic         dn_data_valid, dn_data_ready;
  logic [127:0] dn_data_bits;
  logic [15:0]  dn_data_mask;
  logic [31:0]  dbg_req_cnt, dbg_stall_cnt;

  int checks = 0;
  int errors = 0;

`ifdef MEM_REQ_BUF_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [127:0] DA5 = {16{8'hA5}};
  localparam logic [127:0] D0  = {16{8'h11}};
  localparam logic [127:0] D1  = {16{8'h22}};
  localparam logic [127:0] D2  = {16{8'h33}};
  localparam logic [127:0] D3  = {16{8'h44}};
  localparam logic [127:0] D5  = {16{8'h55}};

  mem_req_buffer #(.DEPTH(4), .ADDR_W(28), .DATA_W(128), .TAG_W(5)) dut (
    .clk(clk), .reset(reset),
    .up_req_valid(up_req_valid), .up_req_rw(up_req_rw), .up_req_addr(up_req_addr),
    .up_req_tag(up_req_tag), .up_req_ready(up_req_ready),
    .up_data_valid(up_data_valid), .up_data_bits(up_data_bits),
    .up_data_mask(up_data_mask), .up_data_ready(up_data_ready),
    .dn_req_valid(dn_req_valid), .dn_req_rw(dn_req_rw), .dn_req_addr(dn_req_addr),
    .dn_req_tag(dn_req_tag), .dn_req_ready(dn_req_ready),
    .dn_data_valid(dn_data_valid), .dn_data_bits(dn_data_bits),
    .dn_data_mask(dn_data_mask), .dn_data_ready(dn_data_ready),
    .dbg_req_cnt(dbg_req_cnt), .dbg_stall_cnt(dbg_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic v, input logic rw, input logic [27:0] a, input logic [4:0] t);
    up_req_valid = v;
    up_req_rw    = rw;
    up_req_addr  = a;
    up_req_tag   = t;
  endtask

  initial begin
    reset = 1'b0;
    set_req(1'b0, 1'b0, 28'h0, 5'h0);
    up_data_valid = 1'b0; up_data_bits = '0; up_data_mask = '0;
    dn_req_ready = 1'b0; dn_data_ready = 1'b0;

    // ---- reset state ----
    tick(); tick();
    check("rst_up_req_ready", up_req_ready, 0);
    check("rst_up_data_ready", up_data_ready, 0);
    check("rst_dn_valids", {dn_req_valid, dn_data_valid}, 0);
    check("rst_dbg", {dbg_req_cnt, dbg_stall_cnt}, 0);
    reset = 1'b1;
    tick();
    check("post_rst_readies", {up_req_ready, up_data_ready}, 2'b11);

    // ---- single read: visible one cycle after accept, for one cycle ----
    dn_req_ready = 1'b1; dn_data_ready = 1'b1;
    set_req(1'b1, 1'b0, 28'h10, 5'd3);
    #1;
    check("rd_same_cycle_valid", dn_req_valid, 0);
    tick();
    set_req(1'b0, 1'b0, 28'h0, 5'h0);
    #1;
    check("rd_valid", dn_req_valid, 1);
    check("rd_fields", {dn_req_rw, dn_req_addr, dn_req_tag}, {1'b0, 28'h10, 5'd3});
    tick();
    check("rd_valid_one_cycle", dn_req_valid, 0);

    // ---- write with data arriving three cycles later ----
    set_req(1'b1, 1'b1, 28'h20, 5'd7);
    tick();
    set_req(1'b0, 1'b0, 28'h0, 5'h0);
    #1;
    check("wr_wait_data_0", dn_req_valid, 0);
    tick();
    check("wr_wait_data_1", dn_req_valid, 0);
    tick();
    up_data_valid = 1'b1; up_data_bits = DA5; up_data_mask = 16'hFFFF;
    #1;
    check("wr_wait_data_2", dn_req_valid, 0);
    tick();
    up_data_valid = 1'b0;
    #1;
    check("wr_req", {dn_req_valid, dn_req_rw, dn_req_addr, dn_req_tag, dn_data_valid},
          {1'b1, 1'b1, 28'h20, 5'd7, 1'b0});
    tick();
    check("wr_data_valid", {dn_req_valid, dn_data_valid}, 2'b01);
    check("wr_data", {dn_data_bits, dn_data_mask}, {DA5, 16'hFFFF});
    tick();
    check("wr_data_done", dn_data_valid, 0);

    // ---- backpressure: 6 reads offered, 4 accepted ----
    dn_req_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_req(1'b1, 1'b0, 28'h100 + 28'(i), 5'(i));
      #1;
      check($sformatf("bp_ready_%0d", i), up_req_ready, (i < 4) ? 1 : 0);
      tick();
    end
    set_req(1'b0, 1'b0, 28'h0, 5'h0);
    #1;
    check("bp_stall_cnt", dbg_stall_cnt, STATS ? 2 : 0);
    check("bp_req_cnt", dbg_req_cnt, STATS ? 2 : 0);
    dn_req_ready = 1'b1;
    #1;
    check("bp_no_bypass", up_req_ready, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_drain_%0d", i), {dn_req_valid, dn_req_addr, dn_req_tag},
            {1'b1, 28'h100 + 28'(i), 5'(i)});
      tick();
    end
    check("bp_drained", dn_req_valid, 0);

    // ---- data first, then two writes: W0 D0 W1 D1 ----
    up_data_valid = 1'b1; up_data_bits = D0; up_data_mask = 16'h00FF;
    tick();
    up_data_bits = D1; up_data_mask = 16'hFF00;
    tick();
    up_data_valid = 1'b0;
    #1;
    check("ord_no_req_yet", {dn_req_valid, dn_data_valid}, 0);
    set_req(1'b1, 1'b1, 28'h30, 5'd1);
    tick();
    set_req(1'b1, 1'b1, 28'h31, 5'd2);
    #1;
    check("ord_w0", {dn_req_valid, dn_req_addr, dn_req_tag}, {1'b1, 28'h30, 5'd1});
    tick();
    set_req(1'b0, 1'b0, 28'h0, 5'h0);
    #1;
    check("ord_d0", {dn_req_valid, dn_data_valid, dn_data_bits, dn_data_mask},
          {1'b0, 1'b1, D0, 16'h00FF});
    tick();
    check("ord_w1", {dn_req_valid, dn_data_valid, dn_req_addr, dn_req_tag},
          {1'b1, 1'b0, 28'h31, 5'd2});
    tick();
    check("ord_d1", {dn_data_valid, dn_data_bits, dn_data_mask}, {1'b1, D1, 16'hFF00});
    tick();
    check("ord_idle", {dn_req_valid, dn_data_valid}, 0);

    // ---- reset while stuck in D_WDATA ----
    dn_data_ready = 1'b0;
    up_data_valid = 1'b1; up_data_bits = D2; up_data_mask = 16'h0F0F;
    tick();
    up_data_bits = D3;
    tick();
    up_data_valid = 1'b0;
    set_req(1'b1, 1'b1, 28'h40, 5'd4);
    tick();
    set_req(1'b1, 1'b1, 28'h41, 5'd5);
    #1;
    check("mid_w2", {dn_req_valid, dn_req_addr}, {1'b1, 28'h40});
    tick();
    set_req(1'b0, 1'b0, 28'h0, 5'h0);
    #1;
    check("mid_d2", {dn_req_valid, dn_data_valid, dn_data_bits}, {1'b0, 1'b1, D2});
    tick();
    check("mid_d2_hold", {dn_data_valid, dn_data_bits, dn_data_mask}, {1'b1, D2, 16'h0F0F});
    check("mid_req_cnt", dbg_req_cnt, STATS ? 9 : 0);
    reset = 1'b0;
    dn_data_ready = 1'b1; dn_req_ready = 1'b1;
    tick();
    check("mid_rst_valids", {dn_req_valid, dn_data_valid}, 0);
    check("mid_rst_readies", {up_req_ready, up_data_ready}, 0);
    check("mid_rst_dbg", {dbg_req_cnt, dbg_stall_cnt}, 0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_rst_quiet_%0d", i), {dn_req_valid, dn_data_valid}, 0);
    end

    // ---- surplus data beat stays queued until a write claims it ----
    up_data_valid = 1'b1; up_data_bits = D5; up_data_mask = 16'h1234;
    tick();
    up_data_valid = 1'b0;
    tick();
    check("surplus_held", {dn_req_valid, dn_data_valid, up_data_ready}, 3'b001);
    set_req(1'b1, 1'b1, 28'h50, 5'd9);
    tick();
    set_req(1'b0, 1'b0, 28'h0, 5'h0);
    #1;
    check("surplus_w5", {dn_req_valid, dn_req_addr, dn_req_tag}, {1'b1, 28'h50, 5'd9});
    tick();
    check("surplus_d5", {dn_data_valid, dn_data_bits, dn_data_mask}, {1'b1, D5, 16'h1234});
    tick();
    check("surplus_done", {dn_req_valid, dn_data_valid}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_req_buffer.md
MEM_REQ_BUFFER -- requirements
Module: mem_req_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: entries per FIFO; power of two, at least 2.
REQ-002 The block SHALL have parameter ADDR_W, default 28: request address width, in 16-byte units.
REQ-003 The block SHALL have parameter DATA_W, default 128: write data width; mask width is DATA_W/8.
REQ-004 The block SHALL have parameter TAG_W, default 5: request tag width.
REQ-005 The block SHALL have port clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have inputs up_req_valid (1), up_req_rw (1, 1=write), up_req_addr (ADDR_W) and up_req_tag (TAG_W): the core's request channel.
REQ-008 The block SHALL have output up_req_ready, 1 bit: request FIFO can accept.
REQ-009 The block SHALL have inputs up_data_valid (1), up_data_bits (DATA_W) and up_data_mask (DATA_W/8): the core's write-data channel.
REQ-010 The block SHALL have output up_data_ready, 1 bit: data FIFO can accept.
REQ-011 The block SHALL have outputs dn_req_valid (1), dn_req_rw (1), dn_req_addr (ADDR_W) and dn_req_tag (TAG_W), and input dn_req_ready (1): the request channel to external memory.
REQ-012 The block SHALL have outputs dn_data_valid (1), dn_data_bits (DATA_W) and dn_data_mask (DATA_W/8), and input dn_data_ready (1): the write-data channel to external memory.
REQ-013 The block SHALL have outputs dbg_req_cnt (32) and dbg_stall_cnt (32): statistics, see Configuration.

Function
REQ-014 The block SHALL hold a request FIFO {rw, addr, tag} and an independent data FIFO {bits, mask}, each DEPTH entries.
REQ-015 The block SHALL drive up_req_ready = request FIFO not full and up_data_ready = data FIFO not full; a pop in the same cycle SHALL NOT make a full FIFO ready (no bypass).
REQ-016 The block SHALL push on valid&&ready; an upstream data beat MAY arrive before, with or after its write request; data beats pair with write requests strictly in order.
REQ-017 The block SHALL register all storage: a request accepted at cycle N is visible on dn_req_* at N+1 at the earliest.
REQ-018 The downstream FSM SHALL have states D_REQ and D_WDATA.
REQ-019 In D_REQ, dn_req_valid SHALL be 1 iff the request FIFO is non-empty and (head is a read, or data FIFO is non-empty); dn_req_* SHALL show the head.
REQ-020 In D_REQ, on dn_req_valid&&dn_req_ready the FSM SHALL pop the head and, if it is a write, go to D_WDATA; for a read it SHALL stay in D_REQ.
REQ-021 In D_WDATA, dn_req_valid SHALL be 0 and dn_data_valid SHALL be 1 with the data FIFO head; on dn_data_ready the FSM SHALL pop it and return to D_REQ.
REQ-022 In D_REQ, dn_data_valid SHALL be 0.
REQ-023 Once asserted, dn_req_valid and dn_data_valid SHALL hold with stable payload until their handshake completes.
REQ-024 Pointers SHALL wrap modulo DEPTH; occupancy counters SHALL be clog2(DEPTH)+1 bits wide.
REQ-025 Surplus data beats with no matching write SHALL remain queued and SHALL NOT be dropped.
REQ-026 Simultaneous push and pop on one FIFO SHALL leave its occupancy unchanged.
REQ-027 The response channel is outside this block; tags SHALL pass through unmodified.

Reset
REQ-028 While reset=0 at a clock edge, the block SHALL empty both FIFOs, enter D_REQ and clear both counters.
REQ-029 During reset, up_req_ready, up_data_ready, dn_req_valid and dn_data_valid SHALL be 0.
REQ-030 A reset in the middle of a transaction SHALL discard all queued and in-flight entries without emitting further downstream handshakes.

Configuration
REQ-031 With macro MEM_REQ_BUF_STATS_EN defined, dbg_req_cnt SHALL increment on each downstream request handshake.
REQ-032 With MEM_REQ_BUF_STATS_EN defined, dbg_stall_cnt SHALL increment on each cycle with up_req_valid&&!up_req_ready; both counters wrap at 2^32.
REQ-033 Without MEM_REQ_BUF_STATS_EN, both dbg outputs SHALL be constant 0 and no counter logic is built.

Verification
REQ-034 Read addr 0x10, tag 3, dn_req_ready=1 -> dn_req_valid for exactly 1 cycle, one cycle after accept, addr 0x10, tag 3.
REQ-035 Write addr 0x20, data sent 3 cycles later -> dn_req_valid stays 0 until the data is queued; then req, then data 0xA5.., mask 0xFFFF.
REQ-036 dn_req_ready=0, 6 reads offered -> 4 accepted, up_req_ready=0, dbg_stall_cnt counts stall cycles; release -> 4 issued in order.
REQ-037 Two writes, data first (D0, D1), then requests W0, W1 -> downstream order W0, D0, W1, D1.
REQ-038 reset=0 asserted while in D_WDATA with 2 entries queued -> next cycle all valids 0; after release no stale handshake occurs.
